// File: rtl/rv_pkg.sv
// Shared types and constants for the register-file writeback path.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;
  localparam int NREGS  = 1 << REG_AW;

  // ABI names of the 32 architectural integer registers.
  typedef enum logic [REG_AW-1:0] {
    ZERO, RA, SP, GP, TP, T0, T1, T2,
    S0, S1, A0, A1, A2, A3, A4, A5,
    A6, A7, S2, S3, S4, S5, S6, S7,
    S8, S9, S10, S11, T3, T4, T5, T6
  } register_alias;

  // One buffered writeback: destination register plus result.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Decode a register index into a one-hot register mask.
  function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    logic [NREGS-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a single result source. Accepts a new
// entry whenever it is empty or being drained this cycle, so a source that
// wins every grant streams at one result per cycle.
module wb_slot
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  output logic              ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_data,
  input  logic              grant,
  output logic              full,
  output logic [REG_AW-1:0] slot_rd,
  output logic [XLEN-1:0]   slot_data
);

  wb_entry_t entry_q;
  logic      capture;

  assign ready     = !full || grant;
  assign capture   = valid && ready;
  assign slot_rd   = entry_q.rd;
  assign slot_data = entry_q.data;

  // Occupancy: a capture wins over a same-edge drain, keeping the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (capture) begin
      full <= 1'b1;
    end else if (grant) begin
      full <= 1'b0;
    end
  end

  // Payload register, loaded on every accepted handshake.
  // NOTE: the payload carries no reset; it is only observed while full=1,
  // and full itself is reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      entry_q <= '{rd: in_rd, data: in_data};
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side master for the 32x32 register file. Buffers one ALU and one
// memory result, grants the older one onto the single write port, exports
// a pending-write mask for decode and counts retired writebacks.
module regfile_writeback
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  output logic              rf_write_en,
  output logic [REG_AW-1:0] rf_rd_addr,
  output logic [XLEN-1:0]   rf_data,
  output logic [NREGS-1:0]  pending_mask,
  output logic [CNT_W-1:0]  wb_count
);

  logic              alu_full, mem_full;
  logic              alu_grant, mem_grant, any_grant;
  logic              alu_cap, mem_cap;
  logic              mem_older;
  logic [REG_AW-1:0] alu_slot_rd, mem_slot_rd;
  logic [XLEN-1:0]   alu_slot_data, mem_slot_data;

  wb_slot u_alu_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (alu_valid),
    .ready     (alu_ready),
    .in_rd     (alu_rd),
    .in_data   (alu_data),
    .grant     (alu_grant),
    .full      (alu_full),
    .slot_rd   (alu_slot_rd),
    .slot_data (alu_slot_data)
  );

  wb_slot u_mem_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (mem_valid),
    .ready     (mem_ready),
    .in_rd     (mem_rd),
    .in_data   (mem_data),
    .grant     (mem_grant),
    .full      (mem_full),
    .slot_rd   (mem_slot_rd),
    .slot_data (mem_slot_data)
  );

  assign alu_cap = alu_valid && alu_ready;
  assign mem_cap = mem_valid && mem_ready;

  // Grant the only full slot, or the older one when both hold data, and
  // steer it onto the register-file write port.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred on the paths that do not assign it.
  always_comb begin
    mem_grant   = 1'b0;
    alu_grant   = 1'b0;
    rf_rd_addr  = '0;
    rf_data     = '0;
    rf_write_en = 1'b0;
    if (mem_full && (!alu_full || mem_older)) begin
      mem_grant = 1'b1;
    end else if (alu_full) begin
      alu_grant = 1'b1;
    end
    if (mem_grant) begin
      rf_rd_addr = mem_slot_rd;
      rf_data    = mem_slot_data;
    end else if (alu_grant) begin
      rf_rd_addr = alu_slot_rd;
      rf_data    = alu_slot_data;
    end
    rf_write_en = (mem_grant || alu_grant) && (rf_rd_addr != ZERO);
  end

  assign any_grant = alu_grant || mem_grant;

  // Destinations of buffered writes; x0 is never a hazard.
  always_comb begin
    pending_mask = '0;
    if (alu_full) pending_mask = pending_mask | rd_onehot(alu_slot_rd);
    if (mem_full) pending_mask = pending_mask | rd_onehot(mem_slot_rd);
    pending_mask[0] = 1'b0;
  end

  // Age flag: a freshly captured entry is always the youngest; a same-edge
  // capture into both slots treats the memory result as issued earlier.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_older <= 1'b0;
    end else if (mem_cap && alu_cap) begin
      mem_older <= 1'b1;
    end else if (alu_cap) begin
      mem_older <= 1'b1;
    end else if (mem_cap) begin
      mem_older <= 1'b0;
    end
  end

  // Retired-writeback counter, one per granted slot, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count <= '0;
    end else if (any_grant) begin
      wb_count <= wb_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected register-file writes are
// queued when stimulus is issued and compared as the write port fires.
module tb_regfile_writeback;
  import rv_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid, mem_valid;
  logic              alu_ready, mem_ready;
  logic [REG_AW-1:0] alu_rd, mem_rd;
  logic [XLEN-1:0]   alu_data, mem_data;
  logic              rf_write_en;
  logic [REG_AW-1:0] rf_rd_addr;
  logic [XLEN-1:0]   rf_data;
  logic [NREGS-1:0]  pending_mask;
  logic [CNT_W-1:0]  wb_count;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;
  int exp_count = 0;
  wb_entry_t sb[$];
  logic [XLEN-1:0] rf_model [NREGS];

  regfile_writeback dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .rf_write_en  (rf_write_en),
    .rf_rd_addr   (rf_rd_addr),
    .rf_data      (rf_data),
    .pending_mask (pending_mask),
    .wb_count     (wb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic issue_alu(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
    exp_count++;
  endtask

  task automatic issue_mem(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] d);
    mem_valid = 1'b1;
    mem_rd    = rd;
    mem_data  = d;
    exp_count++;
  endtask

  // Scoreboard consumer: every write-port pulse must match the oldest
  // outstanding expected write.
  always @(negedge clk) begin
    if (rst_n && rf_write_en) begin
      wr_seen++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed rd=%0d data=%h expected no write", rf_rd_addr, rf_data);
      end
      if (sb.size() != 0) begin
        wb_entry_t e;
        e = sb.pop_front();
        check("wr_rd", 32'(rf_rd_addr), 32'(e.rd));
        check("wr_data", rf_data, e.data);
      end
      rf_model[rf_rd_addr] = rf_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen0;
    rst_n = 1'b0;
    idle();
    alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;
    #3;
    check("rst_write_en", 32'(rf_write_en), 0);
    check("rst_mask", pending_mask, 0);
    check("rst_count", 32'(wb_count), 0);
    check("rst_alu_ready", 32'(alu_ready), 1);
    check("rst_mem_ready", 32'(mem_ready), 1);
    step();
    rst_n = 1'b1;
    step();

    // ALU only: rd=5
    issue_alu(5'd5, 32'hDEADBEEF);
    sb.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    step();
    idle();
    check("alu_only_wen", 32'(rf_write_en), 1);
    check("alu_only_mask", pending_mask, 32'h20);
    step();
    check("alu_only_count", 32'(wb_count), 1);
    check("alu_only_mask_clear", pending_mask, 0);
    check("alu_only_drained", sb.size(), 0);

    // Same edge, same rd: memory result is older and written first.
    issue_mem(5'd7, 32'h11);
    issue_alu(5'd7, 32'h22);
    sb.push_back('{rd: 5'd7, data: 32'h11});
    sb.push_back('{rd: 5'd7, data: 32'h22});
    step();
    idle();
    check("same_mem_ready", 32'(mem_ready), 1);
    check("same_alu_ready", 32'(alu_ready), 0);
    check("same_mask", pending_mask, 32'h80);
    step();
    check("same_second_wen", 32'(rf_write_en), 1);
    step();
    check("same_x7_final", rf_model[7], 32'h22);
    check("same_count", 32'(wb_count), 32'(exp_count));
    check("same_drained", sb.size(), 0);

    // Age flip: memory slot drained and reloaded while ALU waits.
    issue_mem(5'd11, 32'hA11);
    issue_alu(5'd10, 32'hA10);
    sb.push_back('{rd: 5'd11, data: 32'hA11});
    sb.push_back('{rd: 5'd10, data: 32'hA10});
    sb.push_back('{rd: 5'd12, data: 32'hA12});
    step();
    alu_valid = 1'b0;
    check("age_mem_ready", 32'(mem_ready), 1);
    issue_mem(5'd12, 32'hA12);
    step();
    idle();
    check("age_mask", pending_mask, 32'h1400);
    step();
    step();
    check("age_count", 32'(wb_count), 32'(exp_count));
    check("age_drained", sb.size(), 0);

    // rd=0: counted, never written, never pending.
    issue_alu(5'd0, 32'hFFFFFFFF);
    step();
    idle();
    check("x0_wen", 32'(rf_write_en), 0);
    check("x0_mask", pending_mask, 0);
    step();
    check("x0_count", 32'(wb_count), 32'(exp_count));

    // Streaming: eight back-to-back ALU results.
    seen0 = wr_seen;
    for (int i = 0; i < 8; i++) begin
      logic [XLEN-1:0] d;
      d = $urandom;
      issue_alu(5'(8 + i), d);
      sb.push_back('{rd: 5'(8 + i), data: d});
      @(negedge clk);
      check("stream_alu_ready", 32'(alu_ready), 1);
      if (i > 0) check("stream_wen", 32'(rf_write_en), 1);
      step();
    end
    idle();
    step();
    check("stream_writes", wr_seen - seen0, 8);
    check("stream_count", 32'(wb_count), 32'(exp_count));
    check("stream_drained", sb.size(), 0);

    // Reset in the middle of traffic drops both slots.
    issue_alu(5'd13, 32'h13);
    issue_mem(5'd14, 32'h14);
    step();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_wen", 32'(rf_write_en), 0);
    check("midrst_mask", pending_mask, 0);
    check("midrst_count", 32'(wb_count), 0);
    check("midrst_alu_ready", 32'(alu_ready), 1);
    check("midrst_mem_ready", 32'(mem_ready), 1);
    sb.delete();
    exp_count = 0;
    step();
    rst_n = 1'b1;
    step();

    // Wrap: 65535 x0 writebacks, then one real write rolls the counter.
    issue_alu(5'd0, 32'h0);
    repeat (65535) @(posedge clk);
    #1;
    issue_alu(5'd3, 32'hCAFEF00D);
    sb.push_back('{rd: 5'd3, data: 32'hCAFEF00D});
    step();
    idle();
    check("wrap_preload", 32'(wb_count), 32'hFFFF);
    check("wrap_wen", 32'(rf_write_en), 1);
    step();
    check("wrap_count", 32'(wb_count), 0);
    check("wrap_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
